cic_ctrl: RTL and testbench
===========================

CIC_CTRL -- requirements
Module: cic_ctrl

Interface
REQ-001 Parameter DATA_W, default 31, width of CIC output sample and m_data.
REQ-002 Parameter MIN_RATIO, default 2, smallest accepted decimation ratio.
REQ-003 Parameter SETTLE_OUT, default 6, number of CIC output strobes discarded after each restart.
REQ-004 Parameter RST_CYC, default 2, cycles cic_rst is held per restart.
REQ-005 Ports, in this order:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low forces IDLE.
- cfg_valid  in  1  ratio write request.
- cfg_ratio  in  16  requested decimation ratio.
- cfg_ready  out  1  write accepted when high with cfg_valid.
- cfg_err  out  1  one-cycle pulse on rejected write.
- cic_rst  out  1  reset to CIC datapath.
- cic_ratio  out  16  decimation ratio driven to CIC.
- cic_dout  in  DATA_W  CIC output sample.
- cic_dclk  in  1  CIC output clock-enable level.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  output sample.
- ovf  out  1  sticky sample-drop flag.
- ovf_clr  in  1  clears ovf.
- state  out  2  FSM state (IDLE=0, RESTART=1, SETTLE=2, RUN=3).

Function
REQ-006 Sample strobe = cic_dclk high while registered previous cic_dclk low; cic_dout captured in the strobe cycle.
REQ-007 FSM IDLE: cic_rst=1; leaves to RESTART when en=1 and a valid ratio is loaded.
REQ-008 FSM RESTART: cic_rst=1 for exactly RST_CYC cycles, strobes ignored, then SETTLE.
REQ-009 FSM SETTLE: cic_rst=0; discards strobes; after SETTLE_OUT-th strobe, RUN.
REQ-010 FSM RUN: each strobe pushes captured sample into output buffer.
REQ-011 en=0 in any state: next cycle IDLE, output buffer flushed.
REQ-012 cfg_ready=1 in IDLE, SETTLE, RUN; 0 in RESTART.
REQ-013 Accepted write with MIN_RATIO <= cfg_ratio: cic_ratio updated next cycle; if en=1, FSM enters RESTART (also from SETTLE/RUN) and output buffer flushed.
REQ-014 Accepted write with cfg_ratio < MIN_RATIO: cfg_err pulses one cycle, cic_ratio and state unchanged.
REQ-015 Output buffer: 2-entry FIFO, valid/ready; transfer when m_valid & m_ready; m_data stable while m_valid & ~m_ready.
REQ-016 Simultaneous push and pop on full buffer: both take effect, no drop.
REQ-017 Push on full buffer without pop: sample dropped, ovf set next cycle.
REQ-018 ovf_clr and new drop in same cycle: ovf remains 1.
REQ-019 Strobe coinciding with accepted valid write: sample discarded, restart wins.

Reset
REQ-020 rst=1: state=IDLE, cic_rst=1, cic_ratio=0, ratio-loaded flag=0, m_valid=0, m_data=0, cfg_err=0, ovf=0, buffer empty, cfg_ready=0.
REQ-021 rst mid-operation overrides all inputs in that cycle; cfg write in that cycle is lost.

Configuration
REQ-022 Macro CIC_CTRL_DROP_CNT_EN defined: extra output drop_cnt (16 bits), increments per dropped sample, saturates at 16'hFFFF, cleared by rst or ovf_clr (drop in same cycle yields 1).
REQ-023 Macro undefined: no drop_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-024 Shared package cic_pkg holds the state enumeration, ratio width constant (16) and default DATA_W.
REQ-025 Output buffer is sub-module cic_skid_fifo (2-entry, parameterised width); FSM and strobe detect in cic_ctrl.

Verification
REQ-026 rst, en=1, write ratio 8 -> cic_rst high 2 cycles, first 6 strobes discarded, 7th sample appears on m_data with m_valid.
REQ-027 In RUN, write ratio 1 -> cfg_err pulse 1 cycle, cic_ratio stays 8, stream uninterrupted.
REQ-028 In RUN, write ratio 16 -> cic_ratio=16, buffer flushed, RESTART then SETTLE re-entered, no old-ratio sample output.
REQ-029 m_ready=0 across 3 strobes -> 2 samples held in order, 3rd dropped, ovf=1 (drop_cnt=1 with macro); ovf_clr -> ovf=0.
REQ-030 m_ready=1 with buffer full at strobe -> no drop, ovf stays 0.
REQ-031 en deasserted in RUN -> state IDLE next cycle, cic_rst=1, m_valid=0.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimator control slice.
package cic_pkg;
  localparam int RATIO_W = 16;
  localparam int DATA_W_DEF = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTART = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RUN     = 2'd3
  } cic_state_e;
endpackage

// File: rtl/cic_skid_fifo.sv
// Two-entry valid/ready output buffer with flush and drop report.
module cic_skid_fifo #(
  parameter int W = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         drop
);
  logic [W-1:0] mem [2];
  logic [1:0]   cnt;
  logic         rd;
  logic         wr;
  logic         do_push;
  logic         do_pop;

  // Write slot is the read slot when empty or full.
  assign wr      = rd ^ cnt[0];
  assign valid   = (cnt != 2'd0);
  assign dout    = mem[rd];
  assign do_pop  = pop & valid;
  assign do_push = push & ((cnt != 2'd2) | do_pop);
  assign drop    = push & ~do_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      rd     <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      if (do_push) mem[wr] <= din;
      if (do_pop) rd <= ~rd;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/cic_ctrl.sv
// CIC decimator control: restart/settle FSM, strobe capture, output buffer.
// Optional CIC_CTRL_DROP_CNT_EN adds a saturating drop_cnt output.
module cic_ctrl
  import cic_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MIN_RATIO  = 2,
  parameter int SETTLE_OUT = 6,
  parameter int RST_CYC    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_valid,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               cic_rst,
  output logic [RATIO_W-1:0] cic_ratio,
  input  logic [DATA_W-1:0]  cic_dout,
  input  logic               cic_dclk,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               ovf,
  input  logic               ovf_clr,
`ifdef CIC_CTRL_DROP_CNT_EN
  output logic [15:0]        drop_cnt,
`endif
  output logic [1:0]         state
);
  localparam int CNT_W = 8;

  cic_state_e       st_q;
  cic_state_e       st_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dclk_q;
  logic             strobe;
  logic             ratio_ok;
  logic             cfg_fire;
  logic             cfg_good;
  logic             push;
  logic             flush;
  logic             drop;

  assign strobe    = cic_dclk & ~dclk_q;
  assign cfg_ready = ~rst & (st_q != ST_RESTART);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_good  = cfg_ratio >= RATIO_W'(MIN_RATIO);
  assign cic_rst   = rst | (st_q == ST_IDLE) | (st_q == ST_RESTART);
  assign state     = st_q;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    flush = 1'b0;
    if (!en) begin
      st_d  = ST_IDLE;
      flush = 1'b1;
    end else if (cfg_fire && cfg_good) begin
      // A new ratio invalidates any strobe in flight.
      st_d  = ST_RESTART;
      cnt_d = '0;
      flush = 1'b1;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (ratio_ok) begin
            st_d  = ST_RESTART;
            cnt_d = '0;
          end
        end
        ST_RESTART: begin
          if (cnt_q == CNT_W'(RST_CYC - 1)) begin
            st_d  = ST_SETTLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (strobe) begin
            if (cnt_q == CNT_W'(SETTLE_OUT - 1)) begin
              st_d  = ST_RUN;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: push = strobe;
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      dclk_q    <= 1'b0;
      ratio_ok  <= 1'b0;
      cic_ratio <= '0;
      cfg_err   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      dclk_q  <= cic_dclk;
      cfg_err <= cfg_fire & ~cfg_good;
      if (cfg_fire && cfg_good) begin
        cic_ratio <= cfg_ratio;
        ratio_ok  <= 1'b1;
      end
      if (drop) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef CIC_CTRL_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      drop_cnt <= {15'd0, drop};
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  cic_skid_fifo #(.W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (cic_dout),
    .pop   (m_ready),
    .valid (m_valid),
    .dout  (m_data),
    .drop  (drop)
  );
endmodule

// File: tb/tb_cic_ctrl.sv
// Directed self-checking bench for cic_ctrl.
// Build with CIC_CTRL_DROP_CNT_EN to also check drop_cnt.
module tb_cic_ctrl;
  localparam int DW = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cfg_valid;
  logic [15:0]   cfg_ratio;
  logic          cfg_ready;
  logic          cfg_err;
  logic          cic_rst;
  logic [15:0]   cic_ratio;
  logic [DW-1:0] cic_dout;
  logic          cic_dclk;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          ovf;
  logic          ovf_clr;
  logic [1:0]    state;
`ifdef CIC_CTRL_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cic_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ratio (cfg_ratio),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cic_rst   (cic_rst),
    .cic_ratio (cic_ratio),
    .cic_dout  (cic_dout),
    .cic_dclk  (cic_dclk),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
`ifdef CIC_CTRL_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .state     (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    cic_dout = d;
    cic_dclk = 1'b1;
    tick();
    cic_dclk = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1; en = 0; cfg_valid = 0; cfg_ratio = 0;
    cic_dout = 0; cic_dclk = 0; m_ready = 0; ovf_clr = 0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_cic_rst", 32'(cic_rst), 1);
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_ratio", 32'(cic_ratio), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    rst = 0;
    tick();
    chk("idle_cfg_ready", 32'(cfg_ready), 1);
    en = 1;
    tick();
    chk("idle_no_ratio", 32'(state), 0);

    cfg_valid = 1; cfg_ratio = 16'd8;
    tick();
    cfg_valid = 0;
    chk("restart_state", 32'(state), 1);
    chk("restart_ratio", 32'(cic_ratio), 8);
    chk("restart_cic_rst", 32'(cic_rst), 1);
    chk("restart_cfg_ready", 32'(cfg_ready), 0);
    tick();
    chk("restart2_state", 32'(state), 1);
    chk("restart2_cic_rst", 32'(cic_rst), 1);
    tick();
    chk("settle_state", 32'(state), 2);
    chk("settle_cic_rst", 32'(cic_rst), 0);

    for (int i = 0; i < 5; i++) strobe(DW'(100 + i));
    chk("settle5_state", 32'(state), 2);
    strobe(DW'(105));
    chk("run_state", 32'(state), 3);
    chk("settle_discard", 32'(m_valid), 0);
    strobe(DW'('h1234567));
    chk("first_valid", 32'(m_valid), 1);
    chk("first_data", 32'(m_data), 32'h1234567);
    m_ready = 1; tick(); m_ready = 0;
    chk("first_popped", 32'(m_valid), 0);

    cfg_valid = 1; cfg_ratio = 16'd1;
    tick();
    cfg_valid = 0;
    chk("bad_cfg_err", 32'(cfg_err), 1);
    chk("bad_ratio_kept", 32'(cic_ratio), 8);
    chk("bad_state_kept", 32'(state), 3);
    tick();
    chk("bad_err_pulse", 32'(cfg_err), 0);
    strobe(DW'('h55));
    chk("stream_valid", 32'(m_valid), 1);
    chk("stream_data", 32'(m_data), 32'h55);
    m_ready = 1; tick(); m_ready = 0;

    strobe(DW'('hA1));
    strobe(DW'('hB2));
    strobe(DW'('hC3));
    chk("ovf_head", 32'(m_data), 32'hA1);
    chk("ovf_set", 32'(ovf), 1);
`ifdef CIC_CTRL_DROP_CNT_EN
    chk("drop_cnt_1", 32'(drop_cnt), 1);
`endif
    m_ready = 1;
    tick();
    chk("ovf_second", 32'(m_data), 32'hB2);
    tick();
    m_ready = 0;
    chk("ovf_drained", 32'(m_valid), 0);
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk("ovf_clr", 32'(ovf), 0);
`ifdef CIC_CTRL_DROP_CNT_EN
    chk("drop_cnt_clr", 32'(drop_cnt), 0);
`endif

    strobe(DW'('hD4));
    strobe(DW'('hE5));
    cic_dout = DW'('hF6); cic_dclk = 1; m_ready = 1;
    tick();
    m_ready = 0; cic_dclk = 0;
    tick();
    chk("full_pp_head", 32'(m_data), 32'hE5);
    chk("full_pp_no_ovf", 32'(ovf), 0);
    m_ready = 1;
    tick();
    chk("full_pp_tail", 32'(m_data), 32'hF6);
    tick();
    m_ready = 0;
    chk("full_pp_empty", 32'(m_valid), 0);

    strobe(DW'('h11));
    strobe(DW'('h22));
    cic_dout = DW'('h33); cic_dclk = 1; ovf_clr = 1;
    tick();
    ovf_clr = 0; cic_dclk = 0;
    chk("clr_vs_drop", 32'(ovf), 1);
`ifdef CIC_CTRL_DROP_CNT_EN
    chk("drop_cnt_clr_drop", 32'(drop_cnt), 1);
`endif
    tick();
    m_ready = 1; tick(); tick(); m_ready = 0;
    ovf_clr = 1; tick(); ovf_clr = 0;

    strobe(DW'('h77));
    tick();
    chk("hold_data", 32'(m_data), 32'h77);
    cfg_valid = 1; cfg_ratio = 16'd16;
    cic_dout = DW'('h99); cic_dclk = 1;
    tick();
    cfg_valid = 0; cic_dclk = 0;
    chk("rr_ratio", 32'(cic_ratio), 16);
    chk("rr_state", 32'(state), 1);
    chk("rr_flush", 32'(m_valid), 0);
    tick();
    chk("rr_restart2", 32'(state), 1);
    tick();
    chk("rr_settle", 32'(state), 2);
    for (int i = 0; i < 5; i++) strobe(DW'(200 + i));
    chk("rr_settle5", 32'(state), 2);
    strobe(DW'(205));
    chk("rr_run", 32'(state), 3);
    chk("rr_no_old", 32'(m_valid), 0);
    strobe(DW'('h3C3C));
    chk("rr_new_data", 32'(m_data), 32'h3C3C);

    en = 0;
    tick();
    chk("en_off_state", 32'(state), 0);
    chk("en_off_cic_rst", 32'(cic_rst), 1);
    chk("en_off_valid", 32'(m_valid), 0);

    en = 1;
    tick();
    chk("reen_restart", 32'(state), 1);
    rst = 1; cfg_valid = 1; cfg_ratio = 16'd20;
    tick();
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_ratio", 32'(cic_ratio), 0);
    chk("mid_rst_ready", 32'(cfg_ready), 0);
    rst = 0; cfg_valid = 0;
    tick();
    chk("post_rst_idle", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
